// File: rtl/dual_slot_arbiter_pkg.sv
// Shared types and helpers for the dual-slot arbiter.
// Contents: requester count, grant ID width, slot state enum, and the
// ID-to-one-hot conversion used for grant vectors and masking.
package dual_slot_arbiter_pkg;

    localparam int              N_REQ   = 12;
    localparam int              ID_W    = 4;
    localparam logic [ID_W-1:0] ID_NONE = 4'd0;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } slot_state_e;

    // ID k+1 maps to bit k; ID 0 (and unused codes 13..15) map to no bit.
    function automatic logic [N_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
        logic [N_REQ-1:0] v;
        v = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (id == ID_W'(k + 1)) begin
                v[k] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/dual_slot_arbiter_top2_pick.sv
// Combinational pickers for the arbiter.
// priority_encoder: i_vec (12) -> o_id (4), ID of highest set bit, 0 if none.
// top2_pick: i_pending (12) -> o_first / o_second (4 each), the two highest
//            pending requesters in the ID code; o_second is 0 if fewer than two.
module priority_encoder
    import dual_slot_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] i_vec,
    output logic [ID_W-1:0]  o_id
);
    // Scan upward so the highest set bit is the last (winning) assignment.
    always_comb begin
        o_id = ID_NONE;
        for (int k = 0; k < N_REQ; k++) begin
            if (i_vec[k]) begin
                o_id = ID_W'(k + 1);
            end
        end
    end
endmodule

module top2_pick
    import dual_slot_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] i_pending,
    output logic [ID_W-1:0]  o_first,
    output logic [ID_W-1:0]  o_second
);
    logic [N_REQ-1:0] w_rest;

    priority_encoder u_pe_first (
        .i_vec (i_pending),
        .o_id  (o_first)
    );

    assign w_rest = i_pending & ~id_to_onehot(o_first);

    priority_encoder u_pe_second (
        .i_vec (w_rest),
        .o_id  (o_second)
    );
endmodule

// File: rtl/dual_slot_arbiter.sv
// Dual-slot fixed-priority arbiter: two identical slots shared by 12
// requesters (bit 11 highest), each slot holding its owner until the owner
// drops req or the hold limit forces a release.
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_req[11:0]      level request vector
//   o_gnt[11:0]      held grants (at most two bits)
//   o_slot0_id/o_slot1_id  owner ID per slot (1..12), 0 when idle
//   o_slot_busy[1:0] per-slot busy flag
//   o_timeout        one-cycle pulse on any hold-limit release
//
// Slot FSM states:
//   state  | meaning
//   S_IDLE | slot free, may pick from pending this edge
//   S_BUSY | slot owned; releases on req drop or hold limit
module dual_slot_arbiter
    import dual_slot_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [N_REQ-1:0] i_req,
    output logic [N_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]  o_slot0_id,
    output logic [ID_W-1:0]  o_slot1_id,
    output logic [1:0]       o_slot_busy,
    output logic             o_timeout
);
    localparam bit              TO_EN    = (MAX_HOLD > 0);
    localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(MAX_HOLD - 1) : '0;

    slot_state_e               r_state [2];
    logic [1:0][ID_W-1:0]      r_id;
    logic [1:0][CNT_W-1:0]     r_cnt;
    logic [N_REQ-1:0]          r_mask;
    logic [N_REQ-1:0]          r_gnt;
    logic                      r_timeout;

    logic [N_REQ-1:0]          w_pending;
    logic [ID_W-1:0]           w_first;
    logic [ID_W-1:0]           w_second;
    logic [1:0]                w_idle;
    logic [1:0]                w_rel_norm;
    logic [1:0]                w_rel_to;
    logic [1:0][ID_W-1:0]      w_pick;
    logic [1:0][ID_W-1:0]      w_id_nxt;
    logic [N_REQ-1:0]          w_to_set;

    top2_pick u_pick (
        .i_pending (w_pending),
        .o_first   (w_first),
        .o_second  (w_second)
    );

    always_comb begin
        w_pending  = i_req & ~r_gnt & ~r_mask;
        w_idle     = '0;
        w_rel_norm = '0;
        w_rel_to   = '0;
        w_to_set   = '0;
        for (int s = 0; s < 2; s++) begin
            w_idle[s] = (r_state[s] == S_IDLE);
            if (!w_idle[s]) begin
                if (!(|(i_req & id_to_onehot(r_id[s])))) begin
                    w_rel_norm[s] = 1'b1;
                end else if (TO_EN && (r_cnt[s] == CNT_LAST)) begin
                    w_rel_to[s] = 1'b1;
                    w_to_set    = w_to_set | id_to_onehot(r_id[s]);
                end
            end
        end

        // Only slots idle before this edge pick; a slot released on this
        // edge stays idle for one cycle.
        w_pick[0] = w_idle[0] ? w_first : ID_NONE;
        w_pick[1] = w_idle[1] ? (w_idle[0] ? w_second : w_first) : ID_NONE;

        for (int s = 0; s < 2; s++) begin
            if (w_idle[s]) begin
                w_id_nxt[s] = w_pick[s];
            end else if (w_rel_norm[s] || w_rel_to[s]) begin
                w_id_nxt[s] = ID_NONE;
            end else begin
                w_id_nxt[s] = r_id[s];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state[0] <= S_IDLE;
            r_state[1] <= S_IDLE;
            r_id       <= '0;
            r_cnt      <= '0;
            r_mask     <= '0;
            r_gnt      <= '0;
            r_timeout  <= 1'b0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (w_idle[s]) begin
                    if (w_pick[s] != ID_NONE) begin
                        r_state[s] <= S_BUSY;
                    end
                    r_cnt[s] <= '0;
                end else if (w_rel_norm[s] || w_rel_to[s]) begin
                    r_state[s] <= S_IDLE;
                    r_cnt[s]   <= '0;
                end else if (TO_EN) begin
                    r_cnt[s] <= r_cnt[s] + CNT_W'(1);
                end
            end
            r_id      <= w_id_nxt;
            // A mask bit lives until its requester drops req once.
            r_mask    <= (r_mask & i_req) | w_to_set;
            r_timeout <= |w_rel_to;
            r_gnt     <= id_to_onehot(w_id_nxt[0]) | id_to_onehot(w_id_nxt[1]);
        end
    end

    assign o_gnt       = r_gnt;
    assign o_slot0_id  = r_id[0];
    assign o_slot1_id  = r_id[1];
    assign o_slot_busy = {r_state[1] == S_BUSY, r_state[0] == S_BUSY};
    assign o_timeout   = r_timeout;

endmodule

// File: doc/dual_slot_arbiter.md
Name: dual_slot_arbiter

Overview:
- Shares two identical resource slots (slot0, slot1) among 12 requesters using fixed priority; bit 11 is highest.
- Each slot holds one requester until it drops req or exceeds a hold limit.
- Grant IDs use the team's 4-bit priority code: bit k maps to ID k+1, and 0 means none.
- Sits in front of the two-server datapath; it turns raw request vectors into registered, held grants.

Parameters:
- N, 12, number of requesters (fixed at 12 in this revision; ID width 4).
- MAX_HOLD, 16, maximum BUSY cycles per grant; 0 disables the timeout.
- CNT_W, 5, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  12  request vector; bit k from requester k, level-sensitive, held until served.
- gnt  out  12  grant vector; at most two bits set; bit k high while requester k owns a slot.
- slot0_id  out  4  owner ID of slot0 (1..12), 0 when idle.
- slot1_id  out  4  owner ID of slot1 (1..12), 0 when idle.
- slot_busy  out  2  per-slot busy flag; [0]=slot0, [1]=slot1.
- timeout  out  1  one-cycle pulse when any slot is force-released by the hold limit.

Behaviour:
- Reset (synchronous, active-high): both slots IDLE; gnt=0, slot*_id=0, slot_busy=0, timeout=0; hold counters and mask cleared. Reset overrides any grant in progress, with no release handshake.
- All outputs are registered. Grant latency: req sampled at edge t gives gnt at edge t+1.
- Definition: pending = req & ~gnt & ~mask.
- Per-slot FSM, IDLE -> BUSY:
  - Only free slots pick from pending.
  - Both slots IDLE: slot0 takes the highest pending, slot1 takes the second highest. With a single pending request, slot0 takes it and slot1 stays IDLE.
  - Exactly one slot IDLE: it takes the highest pending.
  - A requester is never granted both slots.
- BUSY -> IDLE, normal release: owner's req low at an edge -> slot IDLE, ID cleared, gnt bit cleared at that edge.
  - A freed slot does not regrant on the release edge; earliest regrant is the next edge (2-cycle turnaround).
- BUSY -> IDLE, timeout (MAX_HOLD>0):
  - Hold counter resets to 0 on grant and increments each BUSY cycle.
  - When counter==MAX_HOLD-1 and req is still high: slot releases, mask[k] is set, timeout pulses for 1 cycle.
  - mask[k] clears on the first edge where req[k]=0; a masked requester cannot be granted until it drops and re-raises req.
- Simultaneous events:
  - One slot releasing while the other grants in the same edge is allowed and independent.
  - Both slots timing out in the same cycle produces a single timeout pulse and sets both mask bits.
- Priority among pending is strictly by bit index. There is no fairness beyond the timeout mask.
- Invariants:
  - slot0_id != slot1_id unless both are 0.
  - popcount(gnt) == popcount(slot_busy).
  - gnt[k]=1 iff some slot_id == k+1.

Decomposition:
- Package dual_slot_arbiter_pkg:
  - localparams N_REQ=12, ID_W=4, ID_NONE=4'd0.
  - State enum {S_IDLE, S_BUSY}.
  - Function id_to_onehot (12-bit).
- Sub-module top2_pick (combinational):
  - Input: 12-bit pending vector. Outputs: first/second IDs in the 4-bit code.
  - Built from two instances of the existing 12-bit priority_encoder, with the first winner masked off before the second instance.
- Top level holds two FSM instances, two hold counters, the mask register and the output registers.

Test Plan:
- Reset: drive req=12'hFFF during reset=1 for 3 cycles -> gnt=0, ids=0, slot_busy=0. Release reset -> next edge slot0_id=12, slot1_id=11, gnt=12'hC00.
- Single request: req=12'h004 -> after 1 edge slot0_id=3, slot1_id=0, gnt=12'h004, slot_busy=2'b01.
- Release/regrant: slot0=12 and slot1=11 busy with req=12'hC01; drop req[11] -> slot0 IDLE at that edge, next edge slot0_id=1, gnt=12'h401.
- Timeout (MAX_HOLD=4): hold req=12'h020 -> slot0_id=6 for 4 cycles, then slot0_id=0 with timeout pulsing once. No regrant while req[5] stays high; drop for 1 cycle and re-raise -> granted again 1 edge later.
- Simultaneous events: slot0 release and slot1 free with pending req bit 7 in the same cycle -> slot1_id=8, slot0 IDLE. Then assert reset mid-grant -> all outputs 0 on the next edge.
